// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: decode/execute control, instruction-memory port and decode output.
interface fetch_if;
  logic        hlt;
  logic        override;
  logic [31:0] newpc;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] insn;
  logic [31:0] outpc;
  logic        insn_valid;
  logic        fault;

  modport master (
    input  hlt, override, newpc, imem_ready, imem_rdata,
    output imem_valid, imem_addr, insn, outpc, insn_valid, fault
  );

  modport slave (
    output hlt, override, newpc, imem_ready, imem_rdata,
    input  imem_valid, imem_addr, insn, outpc, insn_valid, fault
  );
endinterface

// File: rtl/fetch_fifo.sv
// Shift-style instruction FIFO: the head always sits in slot 0, so the head is a
// plain register that keeps its last value when the FIFO empties or is flushed.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          nonempty
);
  entry_t        slot [DEPTH];
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;

  always_comb begin
    count_d = flush ? '0 : CW'(count + CW'(push) - CW'(pop));
    wr_idx  = CW'(count - CW'(pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      nonempty <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      count    <= count_d;
      nonempty <= (count_d != '0);
      if (!flush) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++)
          if (pop && CW'(i + 1) < count) slot[i] <= slot[i+1];
        // Incoming word lands just behind the surviving entries.
        for (int unsigned i = 0; i < DEPTH; i++)
          if (push && CW'(i) == wr_idx) slot[i] <= din;
      end
    end
  end

  assign head = slot[0];
endmodule

// File: rtl/fetch.sv
// Fetch stage: owns the PC, issues single-outstanding imem reads, buffers the
// returned words for decode and handles execute redirects.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t        state, state_d;
  logic [31:0]   pc, pc_d;
  logic [31:0]   addr, addr_d;
  logic          req, req_d;
  logic          fault_q, fault_d;
  logic          push, pop, flush;
  logic          fire, stalled, misaligned;
  logic [CW-1:0] count, count_nxt;
  logic          head_valid;
  entry_t        head;
  entry_t        din;

  always_comb begin
    fire       = req && bus.imem_ready;
    stalled    = req && !bus.imem_ready;
    misaligned = (bus.newpc[1:0] != 2'b00);
    din        = '{insn: bus.imem_rdata, pc: pc};
  end

  // Next-state, PC and FIFO control; a redirect outranks push and pop.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.override) begin
          flush = 1'b1;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = stalled ? ST_DRAIN : ST_FAULT;
          end else begin
            pc_d = bus.newpc;
            if (stalled) state_d = ST_DRAIN;
          end
        end else begin
          pop = head_valid && !bus.hlt;
          if (fire) begin
            push = 1'b1;
            pc_d = pc + XLEN'(WORD_BYTES);
          end
        end
      end
      ST_DRAIN: begin
        if (bus.override) begin
          if (misaligned) fault_d = 1'b1;
          else            pc_d    = bus.newpc;
        end
        if (bus.imem_ready) state_d = fault_d ? ST_FAULT : ST_RUN;
      end
      ST_FAULT: ;
      default: state_d = ST_FAULT;
    endcase

    count_nxt = flush ? '0 : CW'(count + CW'(push) - CW'(pop));

    // A raised request holds address and valid until the memory accepts it.
    req_d  = req;
    addr_d = addr;
    if (!stalled) begin
      req_d  = (state_d == ST_RUN) && !fault_d && (count_nxt < CW'(DEPTH));
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      addr    <= '0;
      req     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      addr    <= addr_d;
      req     <= req_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .head     (head),
    .count    (count),
    .nonempty (head_valid)
  );

  assign bus.imem_valid = req;
  assign bus.imem_addr  = addr;
  assign bus.insn       = head.insn;
  assign bus.outpc      = head.pc;
  assign bus.insn_valid = head_valid;
  assign bus.fault      = fault_q;
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Front-end stage of the pipeline. Owns the program counter and issues single-outstanding word reads on the instruction-memory port.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to decode. Decode then feeds execute's opcode fields and inpc.
- Accepts execute's override/newpc redirect: the FIFO is flushed, any in-flight response is discarded, and fetch restarts at the new PC.

Parameters:
RESET_PC, 32'h00000000, PC of the first fetch after reset
DEPTH, 2, instruction FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
hlt  input  1  downstream stall; no pop while high
override  input  1  redirect request from execute
newpc  input  32  redirect target, valid while override=1
imem_valid  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_ready  input  1  response strobe; completes the request this cycle
imem_rdata  input  32  instruction word, valid when imem_ready=1
insn  output  32  instruction at FIFO head
outpc  output  32  PC of insn
insn_valid  output  1  FIFO head valid
fault  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, FIFO count=0, state=RUN, fault=0, imem_valid=0, insn_valid=0, insn=0, outpc=0.
- State machine:
  - RUN: normal fetching.
  - DRAIN: a redirect arrived while a request was outstanding.
  - FAULT: fetching stopped.
- Request rule, RUN:
  - imem_valid=1 when count < DEPTH and fault=0.
  - imem_addr=pc. Address and valid hold stable until imem_ready.
  - At most one request outstanding. A request is never retracted.
- Response in RUN: on imem_valid and imem_ready, the entry {imem_rdata, pc} is pushed and pc <= pc+4. Earliest, imem_ready in the request cycle gives insn_valid the next cycle (1-cycle latency).
- Pop: when insn_valid=1 and hlt=0, the head is removed at the clock edge.
  - Push and pop in the same cycle leave count unchanged.
  - Pop from an empty FIFO is impossible.
- Backpressure: with count=DEPTH, imem_valid=0. A pop makes room, and a new request is raised the cycle after.
- Redirect (override=1 with newpc[1:0]==0), taking precedence over push and pop:
  - FIFO is cleared and pc <= newpc.
  - Request outstanding and imem_ready=0: go to DRAIN. imem_valid and imem_addr keep the old address until imem_ready, the response is discarded, and the block returns to RUN.
  - Request completing in the same cycle (imem_ready=1): the response is discarded and the block stays in RUN.
  - No request outstanding: stay in RUN.
- Redirect during DRAIN: only pc is updated to the latest newpc; the block stays in DRAIN.
- Misaligned redirect (override=1, newpc[1:0]!=0):
  - fault <= 1 and the FIFO is cleared.
  - An outstanding request is drained, then the block enters FAULT. Otherwise it enters FAULT directly.
  - FAULT: imem_valid=0 and insn_valid=0. Only reset exits.
- insn_valid=0 in DRAIN and FAULT. insn and outpc hold their last values when invalid.
- hlt does not stall memory traffic. Fetching continues until the FIFO is full.
- pc arithmetic is modulo 2^32: 32'hFFFFFFFC+4 wraps to 0.
- Reset asserted mid-transaction: state is cleared immediately. The memory side must tolerate a dropped request.

Decomposition:
- Shared package: state encoding (RUN, DRAIN, FAULT), the word-size constant 4, and the NOP encoding 32'h00000013 for bench use.
- Sub-module: fetch_fifo, a parameterised DEPTH x 64-bit synchronous FIFO with flush, push, pop, count, and async active-low reset. The PC/FSM logic stays in fetch.

Test Plan:
- Reset release, imem_ready=1 every cycle, hlt=0 -> imem_addr 0,4,8,... in consecutive cycles; outpc follows one cycle later with insn equal to the supplied word.
- hlt=1 held, zero-wait memory -> exactly 2 pushes (addr 0,4), then imem_valid=0; release hlt -> pops at outpc 0 then 4, and the next request is at 8.
- Request to 8 stalled (imem_ready=0), override with newpc=32'h100 -> DRAIN, imem_addr stays 8 until ready, that data is never presented; next outpc=32'h100.
- override with newpc=32'h40 in the same cycle as imem_ready and a pop -> FIFO empty, the response is dropped, and the next request is 32'h40.
- override with newpc=32'h102 -> fault=1 permanently, imem_valid=0 and insn_valid=0 until rst=0 pulses, then fetch resumes at RESET_PC.
- Redirect to 32'hFFFFFFFC -> outpc FFFFFFFC, then 00000000.
